// File: rtl/nv_nvdla_mcif_bdma_rd_cdt.sv
// BDMA read-request credit gate: admits requests only when the latency FIFO has room
// for the full response, and forwards them through one register stage.
// Optional macro NVDLA_BDMA_RD_CDT_STALL_CNT_EN adds a credit-starvation stall counter.
module nv_nvdla_mcif_bdma_rd_cdt #(
    parameter int LAT_DEPTH = 256,
    parameter int CNT_W     = 9
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             bdma2mcif_rd_req_valid,
    output logic             bdma2mcif_rd_req_ready,
    input  logic [78:0]      bdma2mcif_rd_req_pd,
    input  logic             bdma2mcif_rd_cdt_lat_fifo_pop,
    output logic             noc_rd_req_valid,
    input  logic             noc_rd_req_ready,
    output logic [78:0]      noc_rd_req_pd,
    output logic [CNT_W-1:0] cdt_avail,
    output logic             rd_cdt_idle,
    output logic             err_cdt_ovf,
    output logic             err_oversize
`ifdef NVDLA_BDMA_RD_CDT_STALL_CNT_EN
    ,
    input  logic             rd_cdt_stall_cnt_clr,
    output logic [31:0]      rd_cdt_stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAT_FULL    = CNT_W'(LAT_DEPTH);
    localparam logic [15:0]      LAT_DEPTH_W = 16'(LAT_DEPTH);

    logic [CNT_W-1:0] cdt_q, cdt_d;
    logic             valid_q, valid_d;
    logic [78:0]      pd_q, pd_d;
    logic             ovf_q, ovf_d;
    logic             over_q, over_d;

    logic [15:0] need_s;
    logic [15:0] cdt_ext_s;
    logic        oversize_s;
    logic        stage_free_s;
    logic        credit_ok_s;
    logic        ready_s;
    logic        accept_s;
    logic        acc_norm_s;
    logic        acc_over_s;
    logic        cdt_full_s;

    assign need_s       = {1'b0, bdma2mcif_rd_req_pd[78:64]} + 16'd1;
    assign cdt_ext_s    = {{(16-CNT_W){1'b0}}, cdt_q};
    assign oversize_s   = need_s > LAT_DEPTH_W;
    assign stage_free_s = ~valid_q | noc_rd_req_ready;
    // Credit check deliberately ignores a same-cycle pop.
    assign credit_ok_s  = cdt_ext_s >= need_s;
    assign ready_s      = stage_free_s & (oversize_s | credit_ok_s);
    assign accept_s     = bdma2mcif_rd_req_valid & ready_s;
    assign acc_norm_s   = accept_s & ~oversize_s;
    assign acc_over_s   = accept_s & oversize_s;
    assign cdt_full_s   = cdt_q == LAT_FULL;

    // Credit counter and sticky error next-state.
    always_comb begin
        cdt_d  = cdt_q;
        ovf_d  = ovf_q;
        over_d = over_q | acc_over_s;
        if (acc_norm_s) begin
            // need fits CNT_W here because it is bounded by the current credit count.
            cdt_d = cdt_q - need_s[CNT_W-1:0]
                  + {{(CNT_W-1){1'b0}}, bdma2mcif_rd_cdt_lat_fifo_pop};
        end else if (bdma2mcif_rd_cdt_lat_fifo_pop) begin
            if (cdt_full_s) begin
                ovf_d = 1'b1;
            end else begin
                cdt_d = cdt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cdt_d = cdt_q;
        end
    end

    // Output stage next-state: load on normal admit, drain when the arbiter takes it.
    always_comb begin
        valid_d = valid_q;
        pd_d    = pd_q;
        if (acc_norm_s) begin
            valid_d = 1'b1;
            pd_d    = bdma2mcif_rd_req_pd;
        end else if (noc_rd_req_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cdt_q   <= LAT_FULL;
            valid_q <= 1'b0;
            pd_q    <= 79'd0;
            ovf_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            cdt_q   <= cdt_d;
            valid_q <= valid_d;
            pd_q    <= pd_d;
            ovf_q   <= ovf_d;
            over_q  <= over_d;
        end
    end

    assign bdma2mcif_rd_req_ready = ready_s;
    assign noc_rd_req_valid       = valid_q;
    assign noc_rd_req_pd          = pd_q;
    assign cdt_avail              = cdt_q;
    assign rd_cdt_idle            = cdt_full_s & ~valid_q;
    assign err_cdt_ovf            = ovf_q;
    assign err_oversize           = over_q;

`ifdef NVDLA_BDMA_RD_CDT_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_s;

    // Only credit starvation counts; a busy output stage is not a stall here.
    assign stall_s = bdma2mcif_rd_req_valid & stage_free_s & ~ready_s;

    // Saturating stall counter with clear priority.
    always_comb begin
        stall_d = stall_q;
        if (rd_cdt_stall_cnt_clr) begin
            stall_d = 32'd0;
        end else if (stall_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign rd_cdt_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_bdma_rd_cdt.sv
// Directed bench for nv_nvdla_mcif_bdma_rd_cdt: vector table plus hand sequences.
module tb_nv_nvdla_mcif_bdma_rd_cdt;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [78:0] req_pd;
    logic        pop;
    logic        noc_valid;
    logic        noc_ready;
    logic [78:0] noc_pd;
    logic [8:0]  cdt;
    logic        idle;
    logic        ovf;
    logic        over;
`ifdef NVDLA_BDMA_RD_CDT_STALL_CNT_EN
    logic        stall_clr;
    logic [31:0] stall_cnt;
`endif

    int n_checks;
    int n_fail;

    nv_nvdla_mcif_bdma_rd_cdt #(.LAT_DEPTH(256), .CNT_W(9)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rstn              (rst_n),
        .bdma2mcif_rd_req_valid       (req_valid),
        .bdma2mcif_rd_req_ready       (req_ready),
        .bdma2mcif_rd_req_pd          (req_pd),
        .bdma2mcif_rd_cdt_lat_fifo_pop(pop),
        .noc_rd_req_valid             (noc_valid),
        .noc_rd_req_ready             (noc_ready),
        .noc_rd_req_pd                (noc_pd),
        .cdt_avail                    (cdt),
        .rd_cdt_idle                  (idle),
        .err_cdt_ovf                  (ovf),
        .err_oversize                 (over)
`ifdef NVDLA_BDMA_RD_CDT_STALL_CNT_EN
        ,
        .rd_cdt_stall_cnt_clr         (stall_clr),
        .rd_cdt_stall_cnt             (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [14:0] size;
        logic        pop;
        logic        exp_ready;
        logic        exp_nv;
        logic [8:0]  exp_cdt;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [78:0] mk_pd(input logic [14:0] size, input int tag);
        logic [63:0] addr;
        addr = {32'hA5A5_0000, 32'(tag) << 6};
        return {size, addr};
    endfunction

    logic [78:0] exp_pd;
    logic [78:0] pd_a;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pd    = 79'd0;
        pop       = 1'b0;
        noc_ready = 1'b1;
        exp_pd    = 79'd0;
`ifdef NVDLA_BDMA_RD_CDT_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        //              v     size      pop   rdy   nv    cdt      idle
        vecs[0]  = '{1'b1, 15'd3,   1'b0, 1'b1, 1'b1, 9'd252, 1'b0};
        vecs[1]  = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd253, 1'b0};
        vecs[2]  = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd254, 1'b0};
        vecs[3]  = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd255, 1'b0};
        vecs[4]  = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd256, 1'b1};
        vecs[5]  = '{1'b1, 15'd127, 1'b0, 1'b1, 1'b1, 9'd128, 1'b0};
        vecs[6]  = '{1'b1, 15'd127, 1'b0, 1'b1, 1'b1, 9'd0,   1'b0};
        vecs[7]  = '{1'b1, 15'd0,   1'b0, 1'b0, 1'b0, 9'd0,   1'b0};
        vecs[8]  = '{1'b1, 15'd0,   1'b1, 1'b0, 1'b0, 9'd1,   1'b0};
        vecs[9]  = '{1'b1, 15'd0,   1'b0, 1'b1, 1'b1, 9'd0,   1'b0};
        vecs[10] = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd1,   1'b0};
        vecs[11] = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd2,   1'b0};
        vecs[12] = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd3,   1'b0};
        vecs[13] = '{1'b0, 15'd0,   1'b1, 1'b0, 1'b0, 9'd4,   1'b0};
        vecs[14] = '{1'b1, 15'd3,   1'b1, 1'b1, 1'b1, 9'd1,   1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cdt", 79'(cdt), 79'(9'd256));
        check("rst_noc_valid", 79'(noc_valid), 79'(1'b0));
        check("rst_noc_pd", noc_pd, 79'd0);
        check("rst_idle", 79'(idle), 79'(1'b1));
        check("rst_errs", 79'({ovf, over}), 79'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req_valid = vecs[i].v;
            req_pd    = mk_pd(vecs[i].size, i);
            pop       = vecs[i].pop;
            noc_ready = 1'b1;
            #1;
            if (vecs[i].v) check($sformatf("v%0d_ready", i), 79'(req_ready), 79'(vecs[i].exp_ready));
            if (vecs[i].v && vecs[i].exp_ready) exp_pd = mk_pd(vecs[i].size, i);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_noc_valid", i), 79'(noc_valid), 79'(vecs[i].exp_nv));
            check($sformatf("v%0d_cdt", i), 79'(cdt), 79'(vecs[i].exp_cdt));
            check($sformatf("v%0d_idle", i), 79'(idle), 79'(vecs[i].exp_idle));
            if (vecs[i].exp_nv) check($sformatf("v%0d_noc_pd", i), noc_pd, exp_pd);
        end

        // Back-pressure: first request held, second waits with cdt=1.
        @(negedge clk);
        pd_a      = mk_pd(15'd0, 100);
        req_valid = 1'b1;
        req_pd    = pd_a;
        pop       = 1'b0;
        noc_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("hold_ready", 79'(req_ready), 79'(1'b0));
            @(posedge clk);
            #1;
            check("hold_noc_valid", 79'(noc_valid), 79'(1'b1));
            check("hold_noc_pd", noc_pd, exp_pd);
            check("hold_cdt", 79'(cdt), 79'(9'd1));
            @(negedge clk);
        end
        noc_ready = 1'b1;
        #1;
        check("release_ready", 79'(req_ready), 79'(1'b1));
        @(posedge clk);
        #1;
        check("release_noc_valid", 79'(noc_valid), 79'(1'b1));
        check("release_noc_pd", noc_pd, pd_a);
        check("release_cdt", 79'(cdt), 79'(9'd0));

        // Return all 256 credits.
        @(negedge clk);
        req_valid = 1'b0;
        pop       = 1'b1;
        for (int c = 0; c < 256; c++) @(negedge clk);
        pop = 1'b0;
        #1;
        check("refill_cdt", 79'(cdt), 79'(9'd256));
        check("refill_idle", 79'(idle), 79'(1'b1));
        check("refill_ovf", 79'(ovf), 79'(1'b0));

        // Pop at full alongside an accept is legal.
        req_valid = 1'b1;
        req_pd    = mk_pd(15'd0, 200);
        pop       = 1'b1;
        #1;
        check("full_acc_pop_ready", 79'(req_ready), 79'(1'b1));
        @(posedge clk);
        #1;
        check("full_acc_pop_cdt", 79'(cdt), 79'(9'd256));
        check("full_acc_pop_ovf", 79'(ovf), 79'(1'b0));
        check("full_acc_pop_nv", 79'(noc_valid), 79'(1'b1));
        @(negedge clk);
        req_valid = 1'b0;
        pop       = 1'b0;
        @(posedge clk);
        #1;
        check("drain_nv", 79'(noc_valid), 79'(1'b0));

        // Illegal pop at full.
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1;
        check("ovf_flag", 79'(ovf), 79'(1'b1));
        check("ovf_cdt", 79'(cdt), 79'(9'd256));

        // Oversize request dropped.
        @(negedge clk);
        pop       = 1'b0;
        req_valid = 1'b1;
        req_pd    = mk_pd(15'd299, 300);
        #1;
        check("over_ready", 79'(req_ready), 79'(1'b1));
        @(posedge clk);
        #1;
        check("over_nv", 79'(noc_valid), 79'(1'b0));
        check("over_cdt", 79'(cdt), 79'(9'd256));
        check("over_flag", 79'(over), 79'(1'b1));
        check("over_idle", 79'(idle), 79'(1'b1));
        check("ovf_sticky", 79'(ovf), 79'(1'b1));

        // Reset mid-operation.
        @(negedge clk);
        req_pd = mk_pd(15'd7, 400);
        @(posedge clk);
        #1;
        check("mid_cdt", 79'(cdt), 79'(9'd248));
        @(negedge clk);
        req_valid = 1'b0;
        noc_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cdt", 79'(cdt), 79'(9'd256));
        check("arst_nv", 79'(noc_valid), 79'(1'b0));
        check("arst_pd", noc_pd, 79'd0);
        check("arst_errs", 79'({ovf, over}), 79'(2'b00));
        check("arst_idle", 79'(idle), 79'(1'b1));
        @(negedge clk);
        rst_n     = 1'b1;
        noc_ready = 1'b1;

`ifdef NVDLA_BDMA_RD_CDT_STALL_CNT_EN
        check("stall_rst", 79'(stall_cnt), 79'd0);
        req_valid = 1'b1;
        req_pd    = mk_pd(15'd255, 500);
        @(posedge clk);
        #1;
        check("stall_drain_cdt", 79'(cdt), 79'(9'd0));
        @(negedge clk);
        req_pd = mk_pd(15'd0, 501);
        for (int c = 0; c < 10; c++) begin
            #1;
            check("stall_ready", 79'(req_ready), 79'(1'b0));
            @(negedge clk);
        end
        check("stall_cnt10", 79'(stall_cnt), 79'd10);
        stall_clr = 1'b1;
        @(posedge clk);
        #1;
        check("stall_clr", 79'(stall_cnt), 79'd0);
        @(negedge clk);
        stall_clr = 1'b0;
        req_valid = 1'b0;
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
